ring_monitor16: RTL and testbench
=================================

# ring_monitor16

Receive-side checker for the 16-bit rotating ring counter. It samples the ring's parallel output, locks onto the first pattern, and then verifies that every later sample is exactly one rotation step from the previous one. It reports the current phase, a revolution count, and the hot-bit position for one-hot patterns. Mismatches are flagged with a sticky error. It sits downstream of the ring counter, in the same clock domain, as its consumer.

## Interface
- REV_W, 8, width of the saturating revolution counter
- Clk  in  1  rising-edge clock
- Rst_n  in  1  reset, asynchronous, active-low
- Ring  in  16  parallel ring counter value
- Valid  in  1  Ring holds a new step this cycle
- Resync  in  1  drop lock/error; relock on next Valid sample (or this one, if Valid is also high)
- Locked  out  1  tracking a verified rotation sequence
- Err  out  1  sticky rotation-mismatch flag
- Phase  out  4  rotation steps since lock, mod 16
- Rev  out  REV_W  completed revolutions since lock, saturating
- OneHot  out  1  locked pattern has exactly one bit set
- Pos  out  4  index of the hot bit when OneHot=1, else 0

## Operation
- Rotation step: bit i takes bit i+1 and bit 15 takes bit 0. Expected next value = {Prev[0], Prev[15:1]}.
- Three states: UNLOCKED, LOCKED, ERROR.
- UNLOCKED:
  - Valid=1: Prev<=Ring, Phase<=0, Rev<=0, go to LOCKED.
  - Valid=0: no change.
- LOCKED, Valid=1, Ring==rot(Prev):
  - Prev<=Ring, Phase<=Phase+1.
  - Phase wrapping 15->0 increments Rev. Rev saturates at 2^REV_W-1 and never wraps.
- LOCKED, Valid=1, Ring!=rot(Prev):
  - Go to ERROR, Err<=1.
  - Prev, Phase and Rev freeze at their last good values.
- ERROR: Valid is ignored. Only Resync or reset leaves this state.
- Resync=1 in any state:
  - Err<=0.
  - With Valid=1 in the same cycle, Ring becomes the new Prev, Phase and Rev clear, and the state goes to LOCKED.
  - With Valid=0, the state goes to UNLOCKED and Phase and Rev clear.
  - Resync has priority over the mismatch check.
- Valid=0 in any state: all registers hold.
- Rotation-invariant patterns (16'h0000, 16'hFFFF, 16'hAAAA, 16'h5555 under two steps, etc.):
  - Every matching sample is accepted and Phase still advances per Valid.
  - No special-casing. A transmitter clear to 16'h0000 while Prev is nonzero produces Err.
- OneHot/Pos:
  - Decoded from registered Prev.
  - Valid only while Locked=1; otherwise OneHot=0 and Pos=0.
- Locked = (state==LOCKED). Err = (state==ERROR).

## Timing
- Reset (Rst_n low, asynchronous): state UNLOCKED, Prev=0, Phase=0, Rev=0, Locked=0, Err=0, OneHot=0, Pos=0. Takes effect immediately, without a clock edge.
- Reset release: first sampling edge is the first rising Clk after Rst_n high.
- Latency: all outputs reflect a Valid sample one cycle after the sampling edge. Outputs are registered or decoded only from registers; there is no combinational Ring->output path.
- Throughput: one step per cycle with Valid held high.
- Rev increments on the same edge at which Phase returns to 0.
- Reset asserted mid-revolution discards Phase and Rev. There is no partial-state retention.

## Structure
- Shared package ring_pkg holds:
  - RING_W=16 and POS_W=4;
  - state encoding UNLOCKED=0, LOCKED=1, ERROR=2;
  - a rot_step function implementing {x[0], x[RING_W-1:1]}.
- The ring counter's next-state logic uses the same rot_step so both ends agree on direction.
- Sub-module onehot_enc16: 16-bit one-hot to 4-bit index plus a one-hot-valid flag. It is purely combinational and instantiated once on Prev.

## Test plan
- Lock and revolution: reset, Valid with Ring=16'h8000, then 16 steps 16'h4000 … 16'h0001, 16'h8000.
  - After the first sample: Locked=1, OneHot=1, Pos=15, Phase=0.
  - Pos decrements per step.
  - After the 16th step: Phase=0, Rev=1, Pos=15.
- Mismatch: lock on 16'h8000, then Valid with 16'h2000.
  - Next cycle: Err=1, Locked=0, Phase=0.
  - Three further correct-looking samples leave all outputs unchanged.
- Resync with Valid on 16'h00F0 while in ERROR.
  - Next cycle: Err=0, Locked=1, Phase=0, Rev=0, OneHot=0, Pos=0.
  - Then 16'h0078 gives Phase=1.
- Saturation with REV_W=2: lock on 16'h0001 and run 80 steps.
  - Rev reaches 3 after step 48 and stays 3.
  - Phase=0 at step 80.
- Gaps and async reset:
  - Valid toggling 1,0,0,1 over a valid sequence advances Phase by exactly 2.
  - Rst_n pulsed low between clock edges while locked: Locked, Phase, Rev, Pos drop to 0 before the next edge.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared definitions for the 16-bit rotating ring counter and its receive-side monitor.
// Both ends use rot_step so they agree on the rotation direction.
package ring_pkg;
  localparam int RING_W = 16;
  localparam int POS_W  = 4;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCKED   = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  function automatic logic [RING_W-1:0] rot_step(input logic [RING_W-1:0] x);
    return {x[0], x[RING_W-1:1]};
  endfunction
endpackage

// File: rtl/onehot_enc16.sv
// Combinational one-hot to index encoder; vld is set only for exactly one set bit.
// pos is forced to zero whenever vld is low.
module onehot_enc16
  import ring_pkg::*;
(
  input  logic [RING_W-1:0] vec,
  output logic              vld,
  output logic [POS_W-1:0]  pos
);

  logic [POS_W-1:0] pos_or;

  // OR of set-bit indices equals the index when exactly one bit is set.
  always_comb begin
    pos_or = '0;
    for (int i = 0; i < RING_W; i++) begin
      if (vec[i]) pos_or = pos_or | i[POS_W-1:0];
    end
  end

  assign vld = (vec != '0) && ((vec & (vec - 16'd1)) == '0);
  assign pos = vld ? pos_or : '0;

endmodule

// File: rtl/ring_monitor16.sv
// Locks onto the first ring sample and verifies each later Valid sample is one rotation step on.
// Outputs are registered or decoded from registers only; they reflect a sample one cycle later.
module ring_monitor16
  import ring_pkg::*;
#(
  parameter int REV_W = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [RING_W-1:0] Ring,
  input  logic              Valid,
  input  logic              Resync,
  output logic              Locked,
  output logic              Err,
  output logic [POS_W-1:0]  Phase,
  output logic [REV_W-1:0]  Rev,
  output logic              OneHot,
  output logic [POS_W-1:0]  Pos
);

  localparam logic [REV_W-1:0] REV_MAX = '1;

  logic [1:0]        state;
  logic [RING_W-1:0] prev;
  logic [POS_W-1:0]  phase;
  logic [REV_W-1:0]  rev;
  logic              enc_vld;
  logic [POS_W-1:0]  enc_pos;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ST_UNLOCKED;
      prev  <= '0;
      phase <= '0;
      rev   <= '0;
    end else if (Resync) begin
      phase <= '0;
      rev   <= '0;
      if (Valid) begin
        state <= ST_LOCKED;
        prev  <= Ring;
      end else begin
        state <= ST_UNLOCKED;
      end
    end else if (Valid) begin
      case (state)
        ST_UNLOCKED: begin
          state <= ST_LOCKED;
          prev  <= Ring;
          phase <= '0;
          rev   <= '0;
        end
        ST_LOCKED: begin
          if (Ring == rot_step(prev)) begin
            prev  <= Ring;
            phase <= phase + 4'd1;
            if (phase == '1 && rev != REV_MAX) rev <= rev + REV_W'(1);
          end else begin
            // Prev/Phase/Rev freeze at the last good sample for post-mortem.
            state <= ST_ERROR;
          end
        end
        default: begin
        end
      endcase
    end
  end

  onehot_enc16 u_enc (
    .vec (prev),
    .vld (enc_vld),
    .pos (enc_pos)
  );

  assign Locked = (state == ST_LOCKED);
  assign Err    = (state == ST_ERROR);
  assign Phase  = phase;
  assign Rev    = rev;
  assign OneHot = Locked & enc_vld;
  assign Pos    = OneHot ? enc_pos : '0;

endmodule

// File: tb/tb_ring_monitor16.sv
// Randomized plus directed stimulus against a count-based reference model with a scoreboard queue.
module tb_ring_monitor16;
  localparam int REV_W   = 2;
  localparam int REV_MAX = 3;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b1;
  logic [15:0]       Ring = '0;
  logic              Valid = 1'b0;
  logic              Resync = 1'b0;
  logic              Locked, Err, OneHot;
  logic [3:0]        Phase, Pos;
  logic [REV_W-1:0]  Rev;

  ring_monitor16 #(.REV_W(REV_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Ring(Ring), .Valid(Valid), .Resync(Resync),
    .Locked(Locked), .Err(Err), .Phase(Phase), .Rev(Rev), .OneHot(OneHot), .Pos(Pos)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit locked;
    bit err;
    int phase;
    int rev;
    bit onehot;
    int pos;
  } exp_t;

  exp_t expq[$];

  // Reference state: count of accepted steps since lock rather than phase/rev registers.
  bit          m_locked = 0;
  bit          m_err = 0;
  logic [15:0] m_prev = '0;
  int          m_cnt = 0;

  function automatic logic [15:0] rot_ref(input logic [15:0] x);
    logic [31:0] d;
    d = {x, x};
    return d[16:1];
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.locked = m_locked;
    e.err    = m_err;
    e.phase  = m_cnt % 16;
    e.rev    = (m_cnt / 16 > REV_MAX) ? REV_MAX : m_cnt / 16;
    e.onehot = m_locked && ($countones(m_prev) == 1);
    e.pos    = 0;
    if (e.onehot) begin
      for (int i = 0; i < 16; i++) if (m_prev[i]) e.pos = i;
    end
    return e;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_err = 0; m_prev = '0; m_cnt = 0;
  endtask

  task automatic model_step(input bit v, input logic [15:0] r, input bit rs);
    if (rs) begin
      m_err = 0;
      m_cnt = 0;
      m_locked = v;
      if (v) m_prev = r;
    end else if (v && !m_err) begin
      if (!m_locked) begin
        m_locked = 1; m_prev = r; m_cnt = 0;
      end else if (r == rot_ref(m_prev)) begin
        m_prev = r; m_cnt++;
      end else begin
        m_locked = 0; m_err = 1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t e);
    chk({tag, ".Locked"}, int'(Locked), int'(e.locked));
    chk({tag, ".Err"},    int'(Err),    int'(e.err));
    chk({tag, ".Phase"},  int'(Phase),  e.phase);
    chk({tag, ".Rev"},    int'(Rev),    e.rev);
    chk({tag, ".OneHot"}, int'(OneHot), int'(e.onehot));
    chk({tag, ".Pos"},    int'(Pos),    e.pos);
  endtask

  task automatic drive(input bit v, input logic [15:0] r, input bit rs);
    @(negedge Clk);
    Valid = v; Ring = r; Resync = rs;
    model_step(v, r, rs);
    expq.push_back(model_out());
  endtask

  task automatic step_ok();
    drive(1'b1, rot_ref(m_prev), 1'b0);
  endtask

  // Monitor: every sampling edge with a pending expectation is checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        cmp_all("step", e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [15:0] pats [4] = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h5555};

  initial begin
    logic [15:0] r;
    bit v, rs;
    #1 Rst_n = 1'b0;
    #2;
    model_reset();
    cmp_all("reset", model_out());
    #9 Rst_n = 1'b1;

    // Lock on 8000 and complete one revolution
    drive(1'b1, 16'h8000, 1'b0);
    for (int i = 0; i < 16; i++) step_ok();

    // Mismatch then three samples that would otherwise look valid
    drive(1'b1, 16'h8000, 1'b1);
    drive(1'b1, 16'h2000, 1'b0);
    drive(1'b1, 16'h1000, 1'b0);
    drive(1'b1, 16'h0800, 1'b0);
    drive(1'b1, 16'h0400, 1'b0);

    // Resync with Valid out of ERROR
    drive(1'b1, 16'h00F0, 1'b1);
    drive(1'b1, 16'h0078, 1'b0);

    // Revolution counter saturation
    drive(1'b1, 16'h0001, 1'b1);
    for (int i = 0; i < 80; i++) step_ok();

    // Gaps: only Valid cycles advance
    step_ok();
    drive(1'b0, 16'($urandom), 1'b0);
    drive(1'b0, 16'($urandom), 1'b0);
    step_ok();

    // Async reset between edges while locked
    @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all("async_rst", model_out());
    #1 Rst_n = 1'b1;

    // Resync without Valid drops to UNLOCKED, then clear-to-zero mismatch
    drive(1'b1, 16'h0300, 1'b0);
    step_ok();
    drive(1'b0, 16'h0000, 1'b1);
    drive(1'b1, 16'h0C00, 1'b0);
    drive(1'b1, 16'h0000, 1'b0);

    // Randomized traffic, including rotation-invariant patterns
    for (int n = 0; n < 800; n++) begin
      rs = ($urandom_range(99) < 4);
      v  = ($urandom_range(99) < 75);
      if (m_locked && !rs && $urandom_range(99) < 90) r = rot_ref(m_prev);
      else if ($urandom_range(3) == 0) r = pats[$urandom_range(3)];
      else r = 16'($urandom);
      drive(v, r, rs);
    end

    drive(1'b0, 16'h0000, 1'b0);
    @(posedge Clk);
    #3;
    chk("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
